wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order WB stage and long-latency
//  result sources (divider, uncached load return). Buffers the long-unit results in a 2-entry FIFO.
//  Gives priority to the pipeline, with an anti-starvation override.
//  Drives the registered rf write bus that the regfile and the trace-debug port consume.
// PARAMETERS
//  DW         32  data width of a write-back value
//  AW          5  register address width
//  STARVE_MAX  4  consecutive lost arbitrations before the FIFO head is forced through (>=1)
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-high
//  pipe_valid  in   1   WB-stage instruction valid this cycle
//  pipe_we     in   1   WB-stage instruction writes the RF
//  pipe_waddr  in   AW  WB-stage destination
//  pipe_wdata  in   DW  WB-stage result
//  pipe_ready  out  1   WB stage may retire this cycle (0 = hold WB)
//  lu_valid    in   1   long-unit result offered
//  lu_waddr    in   AW  long-unit destination
//  lu_wdata    in   DW  long-unit result
//  lu_ready    out  1   FIFO accepts (lu_valid & lu_ready = push)
//  rf_we       out  1   registered RF write enable
//  rf_waddr    out  AW  registered RF write address
//  rf_wdata    out  DW  registered RF write data
//  lu_pending  out  1   FIFO non-empty (used by the ID scoreboard)
// BEHAVIOUR
//  - Reset (async): FIFO count=0, starve_cnt=0, state=IDLE, rf_we/rf_waddr/rf_wdata=0.
//    While reset is asserted: pipe_ready=1, lu_ready=1, lu_pending=0.
//  - Latency: a granted write appears on rf_* exactly 1 cycle after grant.
//    A lu push can be granted no earlier than the cycle after the push (no FIFO bypass).
//  - lu_ready = (count<2); it depends on count only, never on the same-cycle pop.
//    A push and a pop in the same cycle are legal when count is 1.
//  - Port need: pipe_need = pipe_valid & pipe_we. If pipe_valid & ~pipe_we, the pipe retires
//    (pipe_ready=1) without using the port, and the FIFO head may be granted in the same cycle.
//  - FSM:
//    IDLE  : count==0. Grant pipe when pipe_need. pipe_ready=1. starve_cnt=0.
//    PEND  : count>0, starve_cnt<STARVE_MAX.
//            If pipe_need: grant pipe, starve_cnt++.
//            Otherwise: pop the head and grant it, starve_cnt=0.
//    FORCE : count>0, starve_cnt==STARVE_MAX. Pop the head and grant it, pipe_ready=0,
//            starve_cnt=0.
//  - Next state is computed from the post-cycle count and starve_cnt:
//    count==0 -> IDLE; else starve_cnt==STARVE_MAX -> FORCE; else PEND.
//  - pipe_ready=0 only in FORCE with pipe_need=1. The WB stage must then hold its bus stable.
//  - Address 0: a granted write to r0 consumes the grant/pop but drives rf_we=0.
//  - Ordering contract: issue logic never lets a pipe write target a register with a pending lu
//    write (lu_pending plus the scoreboard). The arbiter does not check or reorder for this.
//  - starve_cnt saturates at STARVE_MAX; it is [$clog2(STARVE_MAX+1)-1:0] wide.
//  - A FIFO overflow (push while count==2) is impossible by construction.
//    An assertion flags lu_valid & ~lu_ready being treated as a push.
// STRUCTURE
//  - Add to global_defines.vh: WB_ARB_IDLE/PEND/FORCE state encodings (2 bits).
//    Add WS_TO_RF_BUS_WD = 1+AW+DW so rf_* packs as {rf_we,rf_waddr,rf_wdata}.
//  - Sub-module wb_lu_fifo: 2-entry {waddr,wdata} FIFO with push/pop/count, async reset.
//  - Top: FSM, starve counter, grant mux, rf_* output registers.
// TESTING
//  1 Pipe-only: pipe writes r3=0x11 then r4=0x22 on back-to-back cycles -> rf_* shows
//    them 1 cycle later each; pipe_ready stays 1.
//  2 Lu in a gap: lu pushes r5=0xABCD at cycle 0, pipe idle -> rf_we=1, r5=0xABCD at cycle 2;
//    lu_pending is 1 during cycle 1 only.
//  3 Starvation: 1 lu entry queued, pipe_need held 1 -> 4 pipe grants, then FORCE on the 5th:
//    pipe_ready=0 for one cycle, lu written, then pipe resumes.
//  4 Full FIFO: two lu pushes with pipe busy -> lu_ready=0 while count==2.
//    A push and a pop in the same cycle at count==1 keeps count at 1.
//  5 r0 write: pipe writes r0=0xFFFF -> rf_we stays 0, pipe_ready=1.
//    An lu write to r0 is popped with rf_we=0.
//  6 Async reset mid-operation: assert reset with count=2 in FORCE -> rf_we=0 and lu_ready=1
//    before the next clock edge. After release the state is IDLE and lu_pending=0.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared encodings and widths for the write-back port arbiter.
package wb_port_arbiter_pkg;

  localparam int WB_ARB_DW_DEF     = 32;
  localparam int WB_ARB_AW_DEF     = 5;
  localparam int WB_ARB_STARVE_DEF = 4;

  // Long-unit result FIFO geometry
  localparam int WB_ARB_FIFO_DEPTH = 2;
  localparam int WB_ARB_CNT_W      = 2;

  // Arbiter FSM state encodings
  typedef enum logic [1:0] {
    WB_ARB_IDLE  = 2'd0,
    WB_ARB_PEND  = 2'd1,
    WB_ARB_FORCE = 2'd2
  } wb_arb_state_e;

  // Width of the packed rf write bus {we, waddr, wdata}
  function automatic int ws_to_rf_bus_wd(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_lu_fifo.sv
// Two-entry FIFO holding long-unit {waddr, wdata} results awaiting the rf write port.
// The head is read from registered storage, so an entry is never visible in its push cycle.
module wb_lu_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DW = WB_ARB_DW_DEF,
  parameter int AW = WB_ARB_AW_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [AW-1:0]           i_waddr,
  input  logic [DW-1:0]           i_wdata,
  output logic [AW-1:0]           o_head_waddr,
  output logic [DW-1:0]           o_head_wdata,
  output logic [WB_ARB_CNT_W-1:0] o_count
);

  logic [AW-1:0]           r_addr_mem [WB_ARB_FIFO_DEPTH];
  logic [DW-1:0]           r_data_mem [WB_ARB_FIFO_DEPTH];
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [WB_ARB_CNT_W-1:0] r_count;

  // Storage, pointers and occupancy count
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
      for (int i = 0; i < WB_ARB_FIFO_DEPTH; i++) begin
        r_addr_mem[i] <= '0;
        r_data_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_addr_mem[r_wr_ptr] <= i_waddr;
        r_data_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_waddr = r_addr_mem[r_rd_ptr];
  assign o_head_wdata = r_data_mem[r_rd_ptr];
  assign o_count      = r_count;

endmodule

// Protocol checker for the long-unit FIFO: no push when full, no pop when empty.
module wb_lu_fifo_chk
  import wb_port_arbiter_pkg::*;
(
  input logic                    i_clk,
  input logic                    i_reset,
  input logic                    i_push,
  input logic                    i_pop,
  input logic [WB_ARB_CNT_W-1:0] i_count
);

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
    i_push |-> (i_count < 2'd2))
    else $error("wb_lu_fifo: push accepted while full");

  a_no_underflow: assert property (@(posedge i_clk) disable iff (i_reset)
    i_pop |-> (i_count != 2'd0))
    else $error("wb_lu_fifo: pop while empty");

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the in-order WB stage and buffered
// long-latency results. The pipe has priority; after STARVE_MAX lost arbitrations the
// FIFO head is forced through while the WB stage is held.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DW         = WB_ARB_DW_DEF,
  parameter int AW         = WB_ARB_AW_DEF,
  parameter int STARVE_MAX = WB_ARB_STARVE_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_pipe_valid,
  input  logic          i_pipe_we,
  input  logic [AW-1:0] i_pipe_waddr,
  input  logic [DW-1:0] i_pipe_wdata,
  output logic          o_pipe_ready,
  input  logic          i_lu_valid,
  input  logic [AW-1:0] i_lu_waddr,
  input  logic [DW-1:0] i_lu_wdata,
  output logic          o_lu_ready,
  output logic          o_rf_we,
  output logic [AW-1:0] o_rf_waddr,
  output logic [DW-1:0] o_rf_wdata,
  output logic          o_lu_pending
);

  localparam int              SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
  localparam int              RF_BUS_W   = ws_to_rf_bus_wd(AW, DW);

  wb_arb_state_e           r_state;
  wb_arb_state_e           w_state_nxt;
  logic [SW-1:0]           r_starve;
  logic [SW-1:0]           w_starve_nxt;
  logic [RF_BUS_W-1:0]     r_rf_bus;
  logic [RF_BUS_W-1:0]     w_rf_bus_nxt;
  logic [WB_ARB_CNT_W-1:0] w_count;
  logic [WB_ARB_CNT_W-1:0] w_count_nxt;
  logic [AW-1:0]           w_head_waddr;
  logic [DW-1:0]           w_head_wdata;
  logic                    w_pipe_need;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_grant_pipe;
  logic                    w_pipe_ready;

  assign w_pipe_need = i_pipe_valid & i_pipe_we;
  // Acceptance depends on occupancy only, never on a same-cycle pop
  assign w_push      = i_lu_valid & o_lu_ready;

  wb_lu_fifo #(.DW(DW), .AW(AW)) u_lu_fifo (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_waddr      (i_lu_waddr),
    .i_wdata      (i_lu_wdata),
    .o_head_waddr (w_head_waddr),
    .o_head_wdata (w_head_wdata),
    .o_count      (w_count)
  );

  wb_lu_fifo_chk u_lu_fifo_chk (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_count (w_count)
  );

  // FSM state and starvation counter registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= WB_ARB_IDLE;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // Next state from the post-cycle occupancy and starvation count
  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = w_count + 2'd1;
      2'b01:   w_count_nxt = w_count - 2'd1;
      default: w_count_nxt = w_count;
    endcase
    if (w_count_nxt == 2'd0) begin
      w_state_nxt = WB_ARB_IDLE;
    end else if (w_starve_nxt == STARVE_LIM) begin
      w_state_nxt = WB_ARB_FORCE;
    end else begin
      w_state_nxt = WB_ARB_PEND;
    end
  end

  // Grant selection, WB stall and starvation count update per state
  always_comb begin
    w_grant_pipe = 1'b0;
    w_pop        = 1'b0;
    w_pipe_ready = 1'b1;
    w_starve_nxt = '0;
    case (r_state)
      WB_ARB_IDLE: begin
        w_grant_pipe = w_pipe_need;
      end
      WB_ARB_PEND: begin
        if (w_pipe_need) begin
          w_grant_pipe = 1'b1;
          w_starve_nxt = (r_starve == STARVE_LIM) ? r_starve : r_starve + SW'(1);
        end else begin
          w_pop = 1'b1;
        end
      end
      WB_ARB_FORCE: begin
        w_pop        = 1'b1;
        w_pipe_ready = ~w_pipe_need;
      end
      default: begin
        w_grant_pipe = 1'b0;
        w_pop        = 1'b0;
      end
    endcase
  end

  // Grant mux: a granted write to r0 consumes the slot but does not write
  always_comb begin
    if (w_grant_pipe) begin
      w_rf_bus_nxt = {(|i_pipe_waddr), i_pipe_waddr, i_pipe_wdata};
    end else if (w_pop) begin
      w_rf_bus_nxt = {(|w_head_waddr), w_head_waddr, w_head_wdata};
    end else begin
      w_rf_bus_nxt = {1'b0, r_rf_bus[RF_BUS_W-2:0]};
    end
  end

  // Registered rf write bus
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rf_bus <= '0;
    end else begin
      r_rf_bus <= w_rf_bus_nxt;
    end
  end

  assign o_rf_we      = r_rf_bus[RF_BUS_W-1];
  assign o_rf_waddr   = r_rf_bus[DW +: AW];
  assign o_rf_wdata   = r_rf_bus[DW-1:0];
  assign o_pipe_ready = w_pipe_ready;
  assign o_lu_ready   = (w_count < 2'd2);
  assign o_lu_pending = (w_count != 2'd0);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid, pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        pipe_ready;
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        lu_pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_pipe_valid (pipe_valid),
    .i_pipe_we    (pipe_we),
    .i_pipe_waddr (pipe_waddr),
    .i_pipe_wdata (pipe_wdata),
    .o_pipe_ready (pipe_ready),
    .i_lu_valid   (lu_valid),
    .i_lu_waddr   (lu_waddr),
    .i_lu_wdata   (lu_wdata),
    .o_lu_ready   (lu_ready),
    .o_rf_we      (rf_we),
    .o_rf_waddr   (rf_waddr),
    .o_rf_wdata   (rf_wdata),
    .o_lu_pending (lu_pending)
  );

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_pipe(input logic v, input logic we, input logic [4:0] a, input logic [31:0] d);
    pipe_valid = v;
    pipe_we    = we;
    pipe_waddr = a;
    pipe_wdata = d;
  endtask

  task automatic drive_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
    lu_valid = v;
    lu_waddr = a;
    lu_wdata = d;
  endtask

  task automatic check_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    check({tag, ".we"}, {63'd0, rf_we}, {63'd0, we});
    if (we) begin
      check({tag, ".waddr"}, {59'd0, rf_waddr}, {59'd0, a});
      check({tag, ".wdata"}, {32'd0, rf_wdata}, {32'd0, d});
    end
  endtask

  initial begin
    reset = 1'b1;
    drive_pipe(1'b0, 1'b0, 5'd0, 32'd0);
    drive_lu(1'b0, 5'd0, 32'd0);
    settle();
    check("rst.rf_we", {63'd0, rf_we}, 64'd0);
    check("rst.pipe_ready", {63'd0, pipe_ready}, 64'd1);
    check("rst.lu_ready", {63'd0, lu_ready}, 64'd1);
    check("rst.lu_pending", {63'd0, lu_pending}, 64'd0);
    cyc();
    cyc();
    reset = 1'b0;

    // 1: back-to-back pipe writes
    drive_pipe(1'b1, 1'b1, 5'd3, 32'h11);
    settle();
    check("t1.ready0", {63'd0, pipe_ready}, 64'd1);
    cyc();
    check_rf("t1.r3", 1'b1, 5'd3, 32'h11);
    drive_pipe(1'b1, 1'b1, 5'd4, 32'h22);
    settle();
    check("t1.ready1", {63'd0, pipe_ready}, 64'd1);
    cyc();
    check_rf("t1.r4", 1'b1, 5'd4, 32'h22);
    drive_pipe(1'b0, 1'b0, 5'd0, 32'd0);
    cyc();
    check_rf("t1.idle", 1'b0, 5'd0, 32'd0);

    // 2: lu result in a pipe gap, no bypass
    drive_lu(1'b1, 5'd5, 32'hABCD);
    cyc();
    drive_lu(1'b0, 5'd0, 32'd0);
    check_rf("t2.c1", 1'b0, 5'd0, 32'd0);
    check("t2.pend_c1", {63'd0, lu_pending}, 64'd1);
    cyc();
    check_rf("t2.c2", 1'b1, 5'd5, 32'hABCD);
    check("t2.pend_c2", {63'd0, lu_pending}, 64'd0);

    // 3: starvation override after four pipe grants in PEND
    drive_lu(1'b1, 5'd6, 32'h66);
    for (int i = 0; i < 5; i++) begin
      drive_pipe(1'b1, 1'b1, 5'(10 + i), 32'h100 + 32'(i));
      settle();
      check($sformatf("t3.ready%0d", i), {63'd0, pipe_ready}, 64'd1);
      cyc();
      drive_lu(1'b0, 5'd0, 32'd0);
      check_rf($sformatf("t3.pipe%0d", i), 1'b1, 5'(10 + i), 32'h100 + 32'(i));
    end
    drive_pipe(1'b1, 1'b1, 5'd15, 32'h105);
    settle();
    check("t3.force_stall", {63'd0, pipe_ready}, 64'd0);
    cyc();
    check_rf("t3.forced_lu", 1'b1, 5'd6, 32'h66);
    check("t3.pend_after", {63'd0, lu_pending}, 64'd0);
    settle();
    check("t3.resume_ready", {63'd0, pipe_ready}, 64'd1);
    cyc();
    check_rf("t3.resume", 1'b1, 5'd15, 32'h105);

    // 4: full FIFO, then simultaneous push and pop at count 1
    drive_pipe(1'b1, 1'b1, 5'd20, 32'h20);
    drive_lu(1'b1, 5'd8, 32'h88);
    settle();
    check("t4.lu_ready0", {63'd0, lu_ready}, 64'd1);
    cyc();
    drive_pipe(1'b1, 1'b1, 5'd21, 32'h21);
    drive_lu(1'b1, 5'd9, 32'h99);
    settle();
    check("t4.lu_ready1", {63'd0, lu_ready}, 64'd1);
    cyc();
    check_rf("t4.pipe21", 1'b1, 5'd21, 32'h21);
    drive_pipe(1'b0, 1'b0, 5'd0, 32'd0);
    drive_lu(1'b1, 5'd11, 32'hCC);
    settle();
    check("t4.full_not_ready", {63'd0, lu_ready}, 64'd0);
    cyc();
    check_rf("t4.pop_a", 1'b1, 5'd8, 32'h88);
    settle();
    check("t4.ready_at_one", {63'd0, lu_ready}, 64'd1);
    cyc();
    drive_lu(1'b0, 5'd0, 32'd0);
    check_rf("t4.pop_b", 1'b1, 5'd9, 32'h99);
    check("t4.pend_keep", {63'd0, lu_pending}, 64'd1);
    cyc();
    check_rf("t4.pop_c", 1'b1, 5'd11, 32'hCC);
    check("t4.pend_empty", {63'd0, lu_pending}, 64'd0);

    // 5: writes to r0 are swallowed
    drive_pipe(1'b1, 1'b1, 5'd0, 32'hFFFF);
    settle();
    check("t5.ready", {63'd0, pipe_ready}, 64'd1);
    cyc();
    check_rf("t5.pipe_r0", 1'b0, 5'd0, 32'd0);
    drive_pipe(1'b0, 1'b0, 5'd0, 32'd0);
    drive_lu(1'b1, 5'd0, 32'h1234);
    cyc();
    drive_lu(1'b0, 5'd0, 32'd0);
    check("t5.lu_pend", {63'd0, lu_pending}, 64'd1);
    cyc();
    check_rf("t5.lu_r0", 1'b0, 5'd0, 32'd0);
    check("t5.lu_popped", {63'd0, lu_pending}, 64'd0);

    // 6: async reset while FORCE with two entries queued
    for (int i = 0; i < 5; i++) begin
      drive_pipe(1'b1, 1'b1, 5'd1, 32'(i));
      drive_lu(i < 2, 5'(12 + i), 32'hC12 + 32'(i));
      cyc();
    end
    drive_lu(1'b0, 5'd0, 32'd0);
    settle();
    check("t6.force_stall", {63'd0, pipe_ready}, 64'd0);
    check("t6.full", {63'd0, lu_ready}, 64'd0);
    check_rf("t6.last_pipe", 1'b1, 5'd1, 32'd4);
    reset = 1'b1;
    settle();
    check("t6.rst_rf_we", {63'd0, rf_we}, 64'd0);
    check("t6.rst_lu_ready", {63'd0, lu_ready}, 64'd1);
    check("t6.rst_pend", {63'd0, lu_pending}, 64'd0);
    check("t6.rst_pipe_ready", {63'd0, pipe_ready}, 64'd1);
    cyc();
    reset = 1'b0;
    drive_pipe(1'b0, 1'b0, 5'd0, 32'd0);
    cyc();
    check_rf("t6.post_idle", 1'b0, 5'd0, 32'd0);
    check("t6.post_pend", {63'd0, lu_pending}, 64'd0);
    drive_pipe(1'b1, 1'b1, 5'd2, 32'h2222);
    settle();
    check("t6.post_ready", {63'd0, pipe_ready}, 64'd1);
    cyc();
    check_rf("t6.post_write", 1'b1, 5'd2, 32'h2222);
    drive_pipe(1'b0, 1'b0, 5'd0, 32'd0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
